// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for pipe_stage_reg: stage controls, input slice, output slice.
// With PIPE_STAGE_PERF_EN defined the bundle also carries the stall/flush counters.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int OCC_W  = 3
);
    logic              Stall;
    logic              Flush;
    logic              In_Valid;
    logic [CTRL_W-1:0] In_Ctrl;
    logic [DATA_W-1:0] In_Data;
    logic              Out_Valid;
    logic [CTRL_W-1:0] Out_Ctrl;
    logic [DATA_W-1:0] Out_Data;
    logic [OCC_W-1:0]  Occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]       Stall_Cnt;
    logic [15:0]       Flush_Cnt;
`endif

    modport master (
        output Stall,
        output Flush,
        output In_Valid,
        output In_Ctrl,
        output In_Data,
        input  Out_Valid,
        input  Out_Ctrl,
        input  Out_Data,
        input  Occupancy
`ifdef PIPE_STAGE_PERF_EN
        ,
        input  Stall_Cnt,
        input  Flush_Cnt
`endif
    );

    modport slave (
        input  Stall,
        input  Flush,
        input  In_Valid,
        input  In_Ctrl,
        input  In_Data,
        output Out_Valid,
        output Out_Ctrl,
        output Out_Data,
        output Occupancy
`ifdef PIPE_STAGE_PERF_EN
        ,
        output Stall_Cnt,
        output Flush_Cnt
`endif
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic DEPTH-slice inter-stage pipeline register with stall, flush and valid tracking.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush event counters.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int OCC_W  = 3
) (
    input logic          Clk,
    input logic          Reset,
    pipe_stage_reg_if.slave bus
);

    logic [DEPTH-1:0]  r_v;
    logic [CTRL_W-1:0] r_c [DEPTH];
    logic [DATA_W-1:0] r_d [DEPTH];
    logic [OCC_W-1:0]  r_occ;

    logic [DEPTH-1:0]  w_v_nxt;
    logic [CTRL_W-1:0] w_c_nxt [DEPTH];
    logic [DATA_W-1:0] w_d_nxt [DEPTH];
    logic [OCC_W-1:0]  w_occ_nxt;

    // Next slice contents: flush kills valid/ctrl, stall holds, else shift.
    always_comb begin
        w_v_nxt = r_v;
        for (int k = 0; k < DEPTH; k++) begin
            w_c_nxt[k] = r_c[k];
            w_d_nxt[k] = r_d[k];
        end
        if (bus.Flush) begin
            w_v_nxt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                w_c_nxt[k] = '0;
            end
        end else if (!bus.Stall) begin
            w_v_nxt[0] = bus.In_Valid;
            w_c_nxt[0] = bus.In_Valid ? bus.In_Ctrl : '0;
            w_d_nxt[0] = bus.In_Valid ? bus.In_Data : r_d[0];
            for (int k = 1; k < DEPTH; k++) begin
                w_v_nxt[k] = r_v[k-1];
                w_c_nxt[k] = r_c[k-1];
                w_d_nxt[k] = r_d[k-1];
            end
        end
    end

    // Population count of the next valid vector, registered with it.
    always_comb begin
        w_occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[k]);
        end
    end

    // Slice and occupancy registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_c[k] <= '0;
                r_d[k] <= '0;
            end
        end else begin
            r_v   <= w_v_nxt;
            r_occ <= w_occ_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                r_c[k] <= w_c_nxt[k];
                r_d[k] <= w_d_nxt[k];
            end
        end
    end

    assign bus.Out_Valid = r_v[DEPTH-1];
    assign bus.Out_Ctrl  = r_c[DEPTH-1];
    assign bus.Out_Data  = r_d[DEPTH-1];
    assign bus.Occupancy = r_occ;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_ev;
    logic        w_flush_ev;

    assign w_stall_ev = bus.Stall && !bus.Flush && (r_occ != '0);
    assign w_flush_ev = bus.Flush && (|r_v);

    // Saturating counters of stalls holding work and flushes discarding work.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_ev && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.Stall_Cnt = r_stall_cnt;
    assign bus.Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg at DEPTH 1, 2 and 3 sharing one clock/reset.
// Perf counter vectors run only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic Clk;
    logic Reset;
    int   n_chk;
    int   n_fail;

    pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16), .OCC_W(3)) b1 ();
    pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16), .OCC_W(3)) b2 ();
    pipe_stage_reg_if #(.DATA_W(96), .CTRL_W(16), .OCC_W(3)) b3 ();

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(1), .OCC_W(3))
        u_d1 (.Clk(Clk), .Reset(Reset), .bus(b1));
    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(2), .OCC_W(3))
        u_d2 (.Clk(Clk), .Reset(Reset), .bus(b2));
    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(3), .OCC_W(3))
        u_d3 (.Clk(Clk), .Reset(Reset), .bus(b3));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Valid-implies-ctrl invariant on every visible last slice.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("inv_d1", 128'(!b1.Out_Valid && (b1.Out_Ctrl != 0)), 128'd0);
            chk("inv_d2", 128'(!b2.Out_Valid && (b2.Out_Ctrl != 0)), 128'd0);
            chk("inv_d3", 128'(!b3.Out_Valid && (b3.Out_Ctrl != 0)), 128'd0);
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        Reset = 1'b1;
        b1.Stall = 0; b1.Flush = 0; b1.In_Valid = 0; b1.In_Ctrl = 0; b1.In_Data = 0;
        b2.Stall = 0; b2.Flush = 0; b2.In_Valid = 0; b2.In_Ctrl = 0; b2.In_Data = 0;
        b3.Stall = 0; b3.Flush = 0; b3.In_Valid = 0; b3.In_Ctrl = 0; b3.In_Data = 0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("rst_v1", 128'(b1.Out_Valid), 128'd0);
        chk("rst_c1", 128'(b1.Out_Ctrl), 128'd0);
        chk("rst_d1", 128'(b1.Out_Data), 128'd0);
        chk("rst_o1", 128'(b1.Occupancy), 128'd0);
        chk("rst_o3", 128'(b3.Occupancy), 128'd0);

        // Single token through DEPTH=1, then a bubble with held payload.
        b1.In_Valid = 1; b1.In_Ctrl = 16'h00A5; b1.In_Data = 96'h1234;
        tick();
        chk("t1_v", 128'(b1.Out_Valid), 128'd1);
        chk("t1_c", 128'(b1.Out_Ctrl), 128'h00A5);
        chk("t1_d", 128'(b1.Out_Data), 128'h1234);
        chk("t1_o", 128'(b1.Occupancy), 128'd1);
        b1.In_Valid = 0; b1.In_Ctrl = 16'h0077; b1.In_Data = 96'hDEAD;
        tick();
        chk("t1b_v", 128'(b1.Out_Valid), 128'd0);
        chk("t1b_c", 128'(b1.Out_Ctrl), 128'd0);
        chk("t1b_d", 128'(b1.Out_Data), 128'h1234);
        chk("t1b_o", 128'(b1.Occupancy), 128'd0);

        // Fill DEPTH=3 with ctrl 1,2,3.
        for (int i = 1; i <= 3; i++) begin
            b3.In_Valid = 1;
            b3.In_Ctrl = 16'(i);
            b3.In_Data = 96'(16 * i);
            tick();
            chk("t2_occ", 128'(b3.Occupancy), 128'(i));
            chk("t2_v", 128'(b3.Out_Valid), 128'(i == 3));
        end
        chk("t2_c", 128'(b3.Out_Ctrl), 128'd1);
        chk("t2_d", 128'(b3.Out_Data), 128'd16);

        // Stall 4 cycles with a garbage valid input present.
        b3.Stall = 1; b3.In_Valid = 1; b3.In_Ctrl = 16'hFFFF; b3.In_Data = 96'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_sv", 128'(b3.Out_Valid), 128'd1);
            chk("t3_sc", 128'(b3.Out_Ctrl), 128'd1);
            chk("t3_so", 128'(b3.Occupancy), 128'd3);
        end
        b3.Stall = 0; b3.In_Valid = 0;
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk("t3_dv", 128'(b3.Out_Valid), 128'd1);
            chk("t3_dc", 128'(b3.Out_Ctrl), 128'(i));
            chk("t3_dd", 128'(b3.Out_Data), 128'(16 * i));
            chk("t3_do", 128'(b3.Occupancy), 128'(4 - i));
        end
        tick();
        chk("t3_ev", 128'(b3.Out_Valid), 128'd0);
        chk("t3_ec", 128'(b3.Out_Ctrl), 128'd0);
        chk("t3_eo", 128'(b3.Occupancy), 128'd0);

        // DEPTH=2: flush with stall and a valid input drops everything.
        b2.In_Valid = 1; b2.In_Ctrl = 16'h0007; b2.In_Data = 96'h70;
        tick();
        b2.In_Ctrl = 16'h0008; b2.In_Data = 96'h80;
        tick();
        chk("t4_fo", 128'(b2.Occupancy), 128'd2);
        b2.Stall = 1; b2.Flush = 1; b2.In_Ctrl = 16'h0009; b2.In_Data = 96'h90;
        tick();
        chk("t4_o", 128'(b2.Occupancy), 128'd0);
        chk("t4_v", 128'(b2.Out_Valid), 128'd0);
        chk("t4_c", 128'(b2.Out_Ctrl), 128'd0);
        chk("t4_d", 128'(b2.Out_Data), 128'h70);
        b2.Stall = 0; b2.Flush = 0; b2.In_Valid = 0;
        tick();
        chk("t4_ro", 128'(b2.Occupancy), 128'd0);
        chk("t4_rv", 128'(b2.Out_Valid), 128'd0);

        // Asynchronous reset mid-cycle with two tokens inside.
        b2.In_Valid = 1; b2.In_Ctrl = 16'h000B; b2.In_Data = 96'hB0;
        tick();
        b2.In_Ctrl = 16'h000C; b2.In_Data = 96'hC0;
        tick();
        b2.In_Valid = 0;
        chk("t5_pre", 128'(b2.Occupancy), 128'd2);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_o", 128'(b2.Occupancy), 128'd0);
        chk("t5_v", 128'(b2.Out_Valid), 128'd0);
        chk("t5_c", 128'(b2.Out_Ctrl), 128'd0);
        chk("t5_d", 128'(b2.Out_Data), 128'd0);
        b1.In_Valid = 1; b1.In_Ctrl = 16'h0005; b1.In_Data = 96'h55;
        tick();
        chk("t5_hold", 128'(b1.Out_Valid), 128'd0);
        Reset = 1'b0;
        tick();
        chk("t5_cap_v", 128'(b1.Out_Valid), 128'd1);
        chk("t5_cap_c", 128'(b1.Out_Ctrl), 128'h0005);
        b1.In_Valid = 0;

`ifdef PIPE_STAGE_PERF_EN
        // d1 holds one valid token here; stall it and count.
        chk("p_s0", 128'(b1.Stall_Cnt), 128'd0);
        chk("p_f0", 128'(b1.Flush_Cnt), 128'd0);
        b1.Stall = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("p_s3", 128'(b1.Stall_Cnt), 128'd3);
        for (int i = 0; i < 70000; i++) @(posedge Clk);
        #1;
        chk("p_sat", 128'(b1.Stall_Cnt), 128'hFFFF);
        chk("p_f1", 128'(b1.Flush_Cnt), 128'd0);
        chk("p_v", 128'(b1.Out_Valid), 128'd1);
        b1.Stall = 0; b1.Flush = 1;
        tick();
        chk("p_fl", 128'(b1.Flush_Cnt), 128'd1);
        chk("p_fo", 128'(b1.Occupancy), 128'd0);
        tick();
        chk("p_fe", 128'(b1.Flush_Cnt), 128'd1);
        b1.Flush = 0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the pipelined CPU; successor to the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload, a control field and a valid bit through DEPTH register slices.
- Supports stall (hold), flush (bubble insertion) and asynchronous reset.
- Bubbles always carry all-zero control, so write enables (RegWr, MemWr, MemRead, ...) are inert downstream.

Parameters:
- DATA_W, 96: payload width (alu_result, busB, busA, PC, ...); 1..256.
- CTRL_W, 16: control field width (RegWr, MemWr, MemtoReg, MemRead, Rw, cs, ...); 1..64.
- DEPTH, 1: number of cascaded slices (retiming for long stages); 1..4.
- OCC_W, 3: width of the Occupancy output; must satisfy 2^OCC_W > DEPTH.

Ports:
- Clk, input, 1: rising-edge clock.
- Reset, input, 1: asynchronous, active-high reset.
- Stall, input, 1: hold all slices this cycle.
- Flush, input, 1: invalidate all slices this cycle.
- In_Valid, input, 1: upstream stage holds a real instruction.
- In_Ctrl, input, CTRL_W: upstream control field.
- In_Data, input, DATA_W: upstream payload.
- Out_Valid, output, 1: valid bit of the last slice.
- Out_Ctrl, output, CTRL_W: control field of the last slice.
- Out_Data, output, DATA_W: payload of the last slice.
- Occupancy, output, OCC_W: number of valid slices, 0..DEPTH.

Behaviour:
- Slice state: each slice k (0..DEPTH-1) holds {v[k], c[k], d[k]}. Slice 0 is fed from the inputs; slice k is fed from slice k-1. The outputs are slice DEPTH-1.
- Reset (asynchronous, any time, including mid-stall or mid-flush): all v, c and d clear to 0 immediately. Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0. The first capture occurs on the first rising Clk edge after Reset deasserts.
- Priority per rising edge: Reset > Flush > Stall > normal advance.
- Normal advance (Stall=0, Flush=0):
  - v[0] <= In_Valid.
  - c[0] <= In_Valid ? In_Ctrl : 0.
  - d[0] <= In_Valid ? In_Data : d[0] (payload held on bubbles to save toggling; it is never interpreted when v=0).
  - For k>0: {v,c,d}[k] <= {v,c,d}[k-1].
  - Latency from input to output is exactly DEPTH cycles.
- Stall=1, Flush=0: every slice holds, including data. Inputs are ignored and not buffered; upstream must hold its own values. Stall may be held for any number of cycles.
- Flush=1 (Stall is don't-care):
  - All v <= 0 and all c <= 0; d holds.
  - The input is not captured in a flush cycle, even with In_Valid=1.
  - The next cycle resumes normal operation.
- Occupancy: registered population count of v[], updated on the same edge as v[]. It is exact for every combination of Stall, Flush and In_Valid.
- Invariant: v[k]=0 implies c[k]=0 in every cycle. The verifier checks this as an assertion.
- DEPTH=1 degenerates to a single EX/MEM-style register, plus stall, flush and valid.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds output Stall_Cnt[15:0] and output Flush_Cnt[15:0].
  - Stall_Cnt increments on each edge with Stall=1, Flush=0 and Occupancy>0.
  - Flush_Cnt increments on each edge with Flush=1 and at least one v[k]=1 (i.e. a real instruction was discarded).
  - Both counters saturate at 16'hFFFF and clear on Reset.
- Undefined: neither port nor counter exists; the block's area and timing are those of the slices alone.

Test Plan:
1. DEPTH=1, Reset 1→0, then In_Valid=1, In_Ctrl=16'h00A5, In_Data=96'h1234 for one cycle, In_Valid=0 after. Required: Out_Valid=1, Out_Ctrl=16'h00A5, Out_Data=96'h1234 one cycle later. Next cycle: Out_Valid=0, Out_Ctrl=0, Out_Data still 96'h1234.
2. DEPTH=3, inject valid tokens with ctrl 1, 2, 3 on consecutive cycles. Required: outputs appear on cycles 3, 4, 5 in order; Occupancy reads 1, 2, 3 while filling.
3. DEPTH=3, with 3 valid tokens inside, assert Stall for 4 cycles while In_Ctrl=16'hFFFF. Required: outputs and Occupancy=3 frozen for the 4 cycles. After release, tokens drain in order; 16'hFFFF never appears unless In_Valid was 1 after the release.
4. DEPTH=2, Stall=1 and Flush=1 together with In_Valid=1. Required: next cycle Occupancy=0, Out_Valid=0, Out_Ctrl=0; the input token is dropped.
5. Assert Reset asynchronously mid-cycle with Occupancy=2. Required: outputs and Occupancy go to 0 before the next Clk edge.
6. With PIPE_STAGE_PERF_EN defined: 70000 stall cycles with a valid token inside. Required: Stall_Cnt=16'hFFFF; Flush_Cnt unchanged. One flush with a valid token: Flush_Cnt increments by 1. One flush when empty: no change.
